// File: rtl/rpn_pkg.sv
// rpn_pkg: step codes and operand width shared by the RPN entry-flow blocks.
package rpn_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {
    PASSO_A   = 2'b00,
    PASSO_B   = 2'b01,
    PASSO_OP  = 2'b10,
    RESULTADO = 2'b11
  } passo_t;
endpackage

// File: rtl/debouncer_botao.sv
// debouncer_botao: 2-flop synchronizer, stability counter and press-event pulse for one active-low key.
module debouncer_botao #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clock,
  input  logic reset_n,
  input  logic botao_n,
  output logic evento
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic sync1_q, sync2_q;
  logic nivel_q, nivel_d;
  logic evento_q, evento_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic difere, fim;
  // Any sample equal to the accepted level restarts qualification, so bounces never accumulate.
  always_comb begin
    difere   = sync2_q != nivel_q;
    fim      = cnt_q == CNT_MAX;
    cnt_d    = (difere && !fim) ? cnt_q + CNT_W'(1) : '0;
    nivel_d  = (difere && fim) ? sync2_q : nivel_q;
    evento_d = difere && fim && !sync2_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      nivel_q  <= 1'b1;
      cnt_q    <= '0;
      evento_q <= 1'b0;
    end else begin
      sync1_q  <= botao_n;
      sync2_q  <= sync1_q;
      nivel_q  <= nivel_d;
      cnt_q    <= cnt_d;
      evento_q <= evento_d;
    end
  end
  assign evento = evento_q;
endmodule

// File: rtl/controle_passos_rpn.sv
// controle_passos_rpn: RPN entry step sequencer that latches mux operands on debounced confirm presses.
module controle_passos_rpn
  import rpn_pkg::*;
#(
  parameter int DATA_W          = rpn_pkg::DATA_W,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              botao_confirma_n,
  input  logic              botao_limpa_n,
  input  logic [DATA_W-1:0] entrada_a,
  input  logic [DATA_W-1:0] entrada_b,
  input  logic [2:0]        entrada_sel,
  input  logic              entrada_carry_in,
  output logic [1:0]        contador,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [2:0]        reg_sel,
  output logic              reg_carry_in,
  output logic              resultado_valido,
  output logic              pulso_carga
);
  logic ev_confirma, ev_limpa;
  passo_t passo_q, passo_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0] sel_q, sel_d;
  logic ci_q, ci_d, rv_q, rv_d, pulso_q, pulso_d;
  debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_confirma (
    .clock  (clock),
    .reset_n(reset_n),
    .botao_n(botao_confirma_n),
    .evento (ev_confirma)
  );
  debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_limpa (
    .clock  (clock),
    .reset_n(reset_n),
    .botao_n(botao_limpa_n),
    .evento (ev_limpa)
  );
  // Clear has priority over a simultaneous confirm; captured values are the mux outputs for the current step.
  always_comb begin
    passo_d = passo_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    ci_d    = ci_q;
    pulso_d = 1'b0;
    if (ev_limpa) begin
      passo_d = PASSO_A;
      a_d     = '0;
      b_d     = '0;
      sel_d   = '0;
      ci_d    = 1'b0;
    end else if (ev_confirma) begin
      case (passo_q)
        PASSO_A: begin
          a_d     = entrada_a;
          passo_d = PASSO_B;
          pulso_d = 1'b1;
        end
        PASSO_B: begin
          b_d     = entrada_b;
          passo_d = PASSO_OP;
          pulso_d = 1'b1;
        end
        PASSO_OP: begin
          sel_d   = entrada_sel;
          ci_d    = entrada_carry_in;
          passo_d = RESULTADO;
          pulso_d = 1'b1;
        end
        RESULTADO: passo_d = PASSO_A;
      endcase
    end
    rv_d = passo_d == RESULTADO;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      passo_q <= PASSO_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      ci_q    <= 1'b0;
      rv_q    <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      passo_q <= passo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      ci_q    <= ci_d;
      rv_q    <= rv_d;
      pulso_q <= pulso_d;
    end
  end
  assign contador         = passo_q;
  assign reg_a            = a_q;
  assign reg_b            = b_q;
  assign reg_sel          = sel_q;
  assign reg_carry_in     = ci_q;
  assign resultado_valido = rv_q;
  assign pulso_carga      = pulso_q;
endmodule

// File: tb/tb_controle_passos_rpn.sv
// tb_controle_passos_rpn: directed scoreboard bench; every output change is popped against a hand-computed expectation.
module tb_controle_passos_rpn;
  import rpn_pkg::*;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic botao_confirma_n = 1'b1;
  logic botao_limpa_n = 1'b1;
  logic [7:0] entrada_a = '0, entrada_b = '0;
  logic [2:0] entrada_sel = '0;
  logic entrada_carry_in = 1'b0;
  logic [1:0] contador;
  logic [7:0] reg_a, reg_b;
  logic [2:0] reg_sel;
  logic reg_carry_in, resultado_valido, pulso_carga;

  typedef struct packed {
    logic [1:0] c;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] s;
    logic       ci;
    logic       rv;
    logic       p;
  } snap_t;

  snap_t exp_q[$];
  int due_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0, fin_req = 1'b0, fin_done = 1'b0;
  logic [7:0] a_val = '0, b_val = '0;
  logic [2:0] sel_val = '0;
  logic ci_val = 1'b0;

  always #5 clock = ~clock;

  controle_passos_rpn #(.DATA_W(8), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .botao_confirma_n(botao_confirma_n),
    .botao_limpa_n   (botao_limpa_n),
    .entrada_a       (entrada_a),
    .entrada_b       (entrada_b),
    .entrada_sel     (entrada_sel),
    .entrada_carry_in(entrada_carry_in),
    .contador        (contador),
    .reg_a           (reg_a),
    .reg_b           (reg_b),
    .reg_sel         (reg_sel),
    .reg_carry_in    (reg_carry_in),
    .resultado_valido(resultado_valido),
    .pulso_carga     (pulso_carga)
  );

  initial forever @(posedge clock) cyc++;

  // Combinational RPN mux stand-in: only the field selected by the step is meaningful, the rest is noise.
  initial forever begin
    @(negedge clock);
    entrada_a        = (contador == PASSO_A)  ? a_val   : 8'($urandom);
    entrada_b        = (contador == PASSO_B)  ? b_val   : 8'($urandom);
    entrada_sel      = (contador == PASSO_OP) ? sel_val : 3'($urandom);
    entrada_carry_in = (contador == PASSO_OP) ? ci_val  : 1'($urandom);
  end

  task automatic push_one(input snap_t s, input int due);
    exp_q.push_back(s);
    due_q.push_back(due);
  endtask

  task automatic push_load(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] s, input logic ci, input logic rv, input int due);
    push_one({c, a, b, s, ci, rv, 1'b1}, due);
    push_one({c, a, b, s, ci, rv, 1'b0}, -1);
  endtask

  task automatic press(input logic conf, input logic limpa, input int hold);
    @(negedge clock);
    botao_confirma_n = !conf;
    botao_limpa_n    = !limpa;
    repeat (hold) @(negedge clock);
    botao_confirma_n = 1'b1;
    botao_limpa_n    = 1'b1;
    repeat (14) @(negedge clock);
  endtask

  // Monitor: the first enabled sample is the reset state; afterwards every change of the output bundle pops one expectation.
  initial begin
    snap_t cur, prev, e;
    int d;
    logic first;
    first = 1'b1;
    prev = '0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        cur = {contador, reg_a, reg_b, reg_sel, reg_carry_in, resultado_valido, pulso_carga};
        if (first) begin
          checks++;
          if (cur !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: got %h, expected %h", cur, 24'h0);
          end
          first = 1'b0;
        end else if (cur !== prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got %h at cycle %0d, nothing expected", cur, cyc);
          end else begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL outputs: got c=%b a=%h b=%h s=%b ci=%b rv=%b p=%b, expected c=%b a=%h b=%h s=%b ci=%b rv=%b p=%b",
                       cur.c, cur.a, cur.b, cur.s, cur.ci, cur.rv, cur.p, e.c, e.a, e.b, e.s, e.ci, e.rv, e.p);
            end
            if (d >= 0) begin
              checks++;
              if (cyc != d) begin
                errors++;
                $display("FAIL latency: change at cycle %0d, expected cycle %0d", cyc, d);
              end
            end
          end
        end
        prev = cur;
        if (fin_req && !fin_done) begin
          checks++;
          if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_changes: %0d expected changes never seen, expected 0", exp_q.size());
          end
          fin_done = 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    mon_en = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    // Full A, B, OP, RESULTADO sequence
    a_val = 8'h3C;
    push_load(2'b01, 8'h3C, 8'h00, 3'b000, 1'b0, 1'b0, -1);
    press(1'b1, 1'b0, 10);
    b_val = 8'hA5;
    push_load(2'b10, 8'h3C, 8'hA5, 3'b000, 1'b0, 1'b0, -1);
    press(1'b1, 1'b0, 10);
    sel_val = 3'b101;
    ci_val  = 1'b1;
    push_load(2'b11, 8'h3C, 8'hA5, 3'b101, 1'b1, 1'b1, -1);
    press(1'b1, 1'b0, 10);
    push_one({2'b00, 8'h3C, 8'hA5, 3'b101, 1'b1, 1'b0, 1'b0}, -1);
    press(1'b1, 1'b0, 10);
    // Bounces shorter than the qualification window, then a clean hold with exact latency
    a_val = 8'h11;
    @(negedge clock);
    botao_confirma_n = 1'b0;
    repeat (3) @(negedge clock);
    botao_confirma_n = 1'b1;
    @(negedge clock);
    botao_confirma_n = 1'b0;
    repeat (3) @(negedge clock);
    botao_confirma_n = 1'b1;
    repeat (10) @(negedge clock);
    botao_confirma_n = 1'b0;
    push_load(2'b01, 8'h11, 8'hA5, 3'b101, 1'b1, 1'b0, cyc + 7);
    repeat (10) @(negedge clock);
    botao_confirma_n = 1'b1;
    repeat (14) @(negedge clock);
    b_val = 8'h22;
    push_load(2'b10, 8'h11, 8'h22, 3'b101, 1'b1, 1'b0, -1);
    press(1'b1, 1'b0, 10);
    // Clear at PASSO_OP
    push_one(24'h0, -1);
    press(1'b0, 1'b1, 10);
    // Confirm and clear together at PASSO_B
    a_val = 8'h77;
    b_val = 8'h99;
    push_load(2'b01, 8'h77, 8'h00, 3'b000, 1'b0, 1'b0, -1);
    press(1'b1, 1'b0, 10);
    push_one(24'h0, -1);
    press(1'b1, 1'b1, 10);
    // Reset while confirm is half qualified and still held
    a_val = 8'h5A;
    @(negedge clock);
    botao_confirma_n = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    push_load(2'b01, 8'h5A, 8'h00, 3'b000, 1'b0, 1'b0, cyc + 7);
    repeat (12) @(negedge clock);
    botao_confirma_n = 1'b1;
    repeat (14) @(negedge clock);
    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_done; i++) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
